// File: rtl/twin_pair_serializer.sv
// ============================================================================
// Module   : twin_pair_serializer
// Brief    : Accepts (d1, d2) word pairs on a valid/ready input, buffers them
//            in a small pair FIFO and emits each pair as two output beats.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module twin_pair_serializer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_d1,
  input  logic [WIDTH-1:0]         in_d2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   pair_count
);

  localparam int               c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_FULL     = (c_AW + 1)'(DEPTH);
  localparam logic [c_AW:0]    c_CNT_ONE  = (c_AW + 1)'(1);
  localparam logic [c_AW-1:0]  c_PTR_ONE  = c_AW'(1);

  typedef enum logic [0:0] {
    SEND_D1 = 1'b0,
    SEND_D2 = 1'b1
  } phase_t;

  phase_t            r_phase;
  phase_t            w_phase_next;
  logic [c_AW-1:0]   r_wptr;
  logic [c_AW-1:0]   r_rptr;
  logic [c_AW:0]     r_count;
  logic [c_AW-1:0]   w_wptr_next;
  logic [c_AW-1:0]   w_rptr_next;
  logic [c_AW:0]     w_count_next;
  logic [WIDTH-1:0]  r_mem_d1 [DEPTH];
  logic [WIDTH-1:0]  r_mem_d2 [DEPTH];

  logic              w_push;
  logic              w_beat;
  logic              w_pop;

  assign in_ready   = (r_count < c_FULL);
  assign out_valid  = (r_count != '0);
  assign out_data   = (r_phase == SEND_D1) ? r_mem_d1[r_rptr] : r_mem_d2[r_rptr];
  assign out_last   = out_valid && (r_phase == SEND_D2);
  assign pair_count = r_count;

  assign w_push = in_valid && in_ready;
  assign w_beat = out_valid && out_ready;
  // The head pair leaves the FIFO only once its d2 beat has transferred.
  assign w_pop  = w_beat && (r_phase == SEND_D2);

  always_comb begin
    w_phase_next = r_phase;
    w_wptr_next  = r_wptr;
    w_rptr_next  = r_rptr;
    w_count_next = r_count;

    if (w_beat) begin
      case (r_phase)
        SEND_D1: w_phase_next = SEND_D2;
        SEND_D2: w_phase_next = SEND_D1;
        default: w_phase_next = SEND_D1;
      endcase
    end

    if (w_push) begin
      w_wptr_next = r_wptr + c_PTR_ONE;
    end
    if (w_pop) begin
      w_rptr_next = r_rptr + c_PTR_ONE;
    end

    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_CNT_ONE;
      2'b01:   w_count_next = r_count - c_CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_phase <= SEND_D1;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_wptr_next;
      r_rptr  <= w_rptr_next;
      r_count <= w_count_next;
    end
  end

  // Storage needs no reset; a write during reset would be invisible anyway.
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem_d1[r_wptr] <= in_d1;
      r_mem_d2[r_wptr] <= in_d2;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_twin_pair_serializer.sv
// ============================================================================
// Module   : tb_twin_pair_serializer
// Brief    : Scoreboard bench for twin_pair_serializer with directed and
//            randomized traffic against a beat-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_twin_pair_serializer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_d1;
  logic [WIDTH-1:0] in_d2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [$clog2(DEPTH):0] pair_count;

  twin_pair_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_d1      (in_d1),
    .in_d2      (in_d2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .pair_count (pair_count)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    mon_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples just after the falling edge, when inputs are settled
  // for the coming rising edge, compares against the model, then advances it.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      begin
        int  pairs;
        bit  exp_rdy;
        bit  exp_vld;
        pairs   = (exp_q.size() + 1) / 2;
        exp_rdy = (pairs < DEPTH);
        exp_vld = (exp_q.size() != 0);
        if (mon_en) begin
          chk("in_ready",   32'(in_ready),   32'(exp_rdy));
          chk("out_valid",  32'(out_valid),  32'(exp_vld));
          chk("pair_count", 32'(pair_count), 32'(pairs));
          if (exp_vld) begin
            chk("out_data", 32'(out_data), 32'(exp_q[0].data));
            chk("out_last", 32'(out_last), 32'(exp_q[0].last));
          end
        end
        if (!rst) begin
          exp_q.delete();
          mon_en = 1;
        end else begin
          if (exp_vld && out_ready) void'(exp_q.pop_front());
          if (in_valid && exp_rdy) begin
            exp_q.push_back('{data: in_d1, last: 1'b0});
            exp_q.push_back('{data: in_d2, last: 1'b1});
          end
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_d1    = a;
    in_d2    = b;
    forever begin
      #1;
      if (in_ready === 1'b1) begin
        @(negedge clk);
        break;
      end
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL push_timeout: in_ready stuck at %0b, expected 1", in_ready);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_d1     = 8'hAA;
    in_d2     = 8'hAB;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_pair_count", 32'(pair_count), 32'd0);
    @(negedge clk);

    // Single pair
    out_ready = 1'b1;
    push(8'h12, 8'h34);
    repeat (4) @(negedge clk);

    // Backpressure and fill
    out_ready = 1'b0;
    push(8'h01, 8'h02);
    push(8'h03, 8'h04);
    #1;
    chk("full_count", 32'(pair_count), 32'd2);
    chk("full_ready", 32'(in_ready),   32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    in_d1    = 8'hFF;
    in_d2    = 8'hFF;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("stall_data", 32'(out_data), 32'h01);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("drain_valid", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Streaming with wrap and a 1,1,0 ready pattern
    fork
      begin
        for (int i = 0; i < 6; i++) push(8'(8'h10 + i), 8'(8'h20 + i));
      end
      begin
        for (int k = 0; k < 40; k++) begin
          out_ready = ((k % 3) != 2);
          @(negedge clk);
        end
      end
    join
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("stream_count", 32'(pair_count), 32'd0);
    @(negedge clk);

    // Mid-pair reset: d2 of the half-sent pair must vanish
    out_ready = 1'b0;
    push(8'h5A, 8'hA5);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_count", 32'(pair_count), 32'd0);
    chk("midrst_valid", 32'(out_valid),  32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    push(8'h77, 8'h88);
    #1;
    chk("after_rst_d1", 32'(out_data), 32'h77);
    repeat (3) @(negedge clk);

    // Simultaneous push and pop with count 1 in the d2 phase
    out_ready = 1'b0;
    push(8'hE1, 8'hE2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_d1     = 8'hC3;
    in_d2     = 8'h3C;
    #1;
    chk("sim_last", 32'(out_last), 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("sim_count", 32'(pair_count), 32'd1);
    chk("sim_data",  32'(out_data),   32'hC3);
    chk("sim_last2", 32'(out_last),   32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 59) != 0);
      in_valid  = $urandom_range(0, 1) != 0;
      in_d1     = 8'($urandom);
      in_d2     = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("final_empty", 32'(out_valid), 32'd0);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
